// File: rtl/dtfm_rx_pkg.sv
// Shared types and mode encodings for the multi-lane serial frame receiver.
package dtfm_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rxState_t;

  localparam logic EDGE_REAR  = 1'b0;
  localparam logic EDGE_FRONT = 1'b1;
  localparam logic MSB_FIRST  = 1'b0;
  localparam logic LSB_FIRST  = 1'b1;

endpackage

// File: rtl/dtfm_edge_sync.sv
// Three-flop synchroniser for one asynchronous control line, with front/rear
// pulses derived from the second and third stages.
module dtfm_edge_sync (
  input  logic cClk,
  input  logic reset,
  input  logic sigIn,
  output logic front,
  output logic rear
);

  logic [2:0] stages;

  always_ff @(posedge cClk) begin
    if (reset) stages <= '0;
    else       stages <= {stages[1:0], sigIn};
  end

  assign front = stages[1] & ~stages[2];
  assign rear  = ~stages[1] & stages[2];

endmodule

// File: rtl/dtfm_rx_lanes.sv
// Multi-lane serial deserialiser: frames on sync, captures lane bits on a
// selected dClk edge, and hands completed words to a single holding register.
//
// state | meaning
// IDLE  | after reset; capture edges ignored until the first sync front
// RECV  | framing active; bits shift in, words complete, sync restarts the frame
module dtfm_rx_lanes
  import dtfm_rx_pkg::*;
#(
  parameter int WORD_W      = 16,
  parameter int LANES       = 4,
  parameter int FRAME_WORDS = 64
) (
  input  logic                             cClk,
  input  logic                             reset,
  input  logic                             dClk,
  input  logic [LANES-1:0]                 data,
  input  logic                             sync,
  input  logic                             edgeSel,
  input  logic                             lsbFirst,
  output logic [LANES*WORD_W-1:0]          word,
  output logic [$clog2(FRAME_WORDS)-1:0]   wordIdx,
  output logic                             valid,
  input  logic                             ack,
  output logic                             overrun,
  output logic                             frameErr
);

  localparam int BIT_W = $clog2(WORD_W);
  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam int CNT_W = $clog2(FRAME_WORDS + 2);

  rxState_t            state;
  logic                dFront, dRear, syncFront, syncRear;
  logic [LANES-1:0]    laneS1, laneS2, laneS3;
  logic [BIT_W-1:0]    bitCnt, bitPos;
  logic [IDX_W-1:0]    wordIdxCnt;
  logic [CNT_W-1:0]    rxCount;
  logic [WORD_W-1:0]   shiftWord [LANES];
  logic [WORD_W-1:0]   nextShift [LANES];
  logic [LANES*WORD_W-1:0] nextWordFlat;
  logic                captureEdge, lastBit, holdFree;

  dtfm_edge_sync uDClkSync (
    .cClk  (cClk),
    .reset (reset),
    .sigIn (dClk),
    .front (dFront),
    .rear  (dRear)
  );

  dtfm_edge_sync uSyncSync (
    .cClk  (cClk),
    .reset (reset),
    .sigIn (sync),
    .front (syncFront),
    .rear  (syncRear)
  );

  // Lane data takes the same path depth as dClk, so stage 2 lines up with the detected edge.
  always_ff @(posedge cClk) begin
    if (reset) begin
      laneS1 <= '0;
      laneS2 <= '0;
      laneS3 <= '0;
    end else begin
      laneS1 <= data;
      laneS2 <= laneS1;
      laneS3 <= laneS2;
    end
  end

  assign captureEdge = (edgeSel == EDGE_FRONT) ? dFront : dRear;
  assign lastBit     = (bitCnt == BIT_W'(WORD_W - 1));
  assign holdFree    = !valid || ack;

  always_comb begin
    bitPos       = (lsbFirst == LSB_FIRST) ? bitCnt : (BIT_W'(WORD_W - 1) - bitCnt);
    nextWordFlat = '0;
    for (int k = 0; k < LANES; k++) begin
      nextShift[k]         = shiftWord[k];
      nextShift[k][bitPos] = laneS2[k];
      nextWordFlat[k*WORD_W +: WORD_W] = nextShift[k];
    end
  end

  always_ff @(posedge cClk) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= '0;
      wordIdxCnt <= '0;
      rxCount    <= '0;
      word       <= '0;
      wordIdx    <= '0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      frameErr   <= 1'b0;
      for (int k = 0; k < LANES; k++) shiftWord[k] <= '0;
    end else begin
      frameErr <= 1'b0;
      if (valid && ack) valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (syncFront) begin
            state      <= RECV;
            bitCnt     <= '0;
            wordIdxCnt <= '0;
            rxCount    <= '0;
            for (int k = 0; k < LANES; k++) shiftWord[k] <= '0;
          end
        end

        RECV: begin
          if (syncFront) begin
            // A coincident capture edge loses to sync; its bit is discarded.
            frameErr   <= (rxCount != CNT_W'(FRAME_WORDS)) || (bitCnt != '0);
            bitCnt     <= '0;
            wordIdxCnt <= '0;
            rxCount    <= '0;
            for (int k = 0; k < LANES; k++) shiftWord[k] <= '0;
          end else if (captureEdge) begin
            if (lastBit) begin
              bitCnt     <= '0;
              wordIdxCnt <= (wordIdxCnt == IDX_W'(FRAME_WORDS - 1)) ? '0 : wordIdxCnt + 1'b1;
              if (rxCount != CNT_W'(FRAME_WORDS + 1)) rxCount <= rxCount + 1'b1;
              for (int k = 0; k < LANES; k++) shiftWord[k] <= '0;
              if (holdFree) begin
                word    <= nextWordFlat;
                wordIdx <= wordIdxCnt;
                valid   <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bitCnt <= bitCnt + 1'b1;
              for (int k = 0; k < LANES; k++) shiftWord[k] <= nextShift[k];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtfm_rx_lanes.sv
// Directed bench for dtfm_rx_lanes with two 16-bit lanes and 4-word frames.
module tb_dtfm_rx_lanes;

  localparam int WORD_W      = 16;
  localparam int LANES       = 2;
  localparam int FRAME_WORDS = 4;

  logic              cClk = 1'b0;
  logic              reset = 1'b1;
  logic              dClk = 1'b1;
  logic [LANES-1:0]  data = '0;
  logic              sync = 1'b0;
  logic              edgeSel = 1'b0;
  logic              lsbFirst = 1'b0;
  logic              ack = 1'b0;
  logic [LANES*WORD_W-1:0] word;
  logic [1:0]        wordIdx;
  logic              valid, overrun, frameErr;

  int checks = 0;
  int failures = 0;
  int errPulses = 0;
  int e0;

  dtfm_rx_lanes #(
    .WORD_W      (WORD_W),
    .LANES       (LANES),
    .FRAME_WORDS (FRAME_WORDS)
  ) dut (
    .cClk     (cClk),
    .reset    (reset),
    .dClk     (dClk),
    .data     (data),
    .sync     (sync),
    .edgeSel  (edgeSel),
    .lsbFirst (lsbFirst),
    .word     (word),
    .wordIdx  (wordIdx),
    .valid    (valid),
    .ack      (ack),
    .overrun  (overrun),
    .frameErr (frameErr)
  );

  always #5 cClk = ~cClk;

  // Counts every cycle frameErr is high, so a stretched pulse shows as >1.
  always begin
    @(posedge cClk);
    #2;
    if (frameErr === 1'b1) errPulses++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic waitCyc(input int n);
    repeat (n) @(negedge cClk);
  endtask

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic resetDut(input logic eSel, input logic lsb);
    reset    = 1'b1;
    sync     = 1'b0;
    ack      = 1'b0;
    data     = '0;
    edgeSel  = eSel;
    lsbFirst = lsb;
    dClk     = ~eSel;
    waitCyc(3);
    reset = 1'b0;
    waitCyc(6);
  endtask

  task automatic sendSync();
    sync = 1'b1;
    waitCyc(5);
    sync = 1'b0;
    waitCyc(5);
  endtask

  // Toggle away from the idle level is the capture edge; ackAtCapture
  // raises ack exactly in the cycle the DUT sees that edge.
  task automatic sendBit(input logic [LANES-1:0] b, input bit ackAtCapture);
    data = b;
    waitCyc(2);
    dClk = ~dClk;
    if (ackAtCapture) begin
      waitCyc(2);
      ack = 1'b1;
      waitCyc(1);
      ack = 1'b0;
      waitCyc(1);
    end else begin
      waitCyc(4);
    end
    dClk = ~dClk;
    waitCyc(4);
  endtask

  task automatic sendWord(input logic [15:0] w0, input logic [15:0] w1,
                          input bit lsbF, input bit ackLast);
    int pos;
    for (int n = 0; n < WORD_W; n++) begin
      pos = lsbF ? n : WORD_W - 1 - n;
      sendBit({w1[pos], w0[pos]}, ackLast && (n == WORD_W - 1));
    end
  endtask

  task automatic consume();
    ack = 1'b1;
    waitCyc(1);
    ack = 1'b0;
    waitCyc(1);
  endtask

  initial begin
    logic [15:0] pat;

    // Reset state
    resetDut(1'b0, 1'b0);
    checkVal("rst_word", word, 0);
    checkVal("rst_idx", wordIdx, 0);
    checkVal("rst_valid", valid, 0);
    checkVal("rst_overrun", overrun, 0);
    checkVal("rst_frameerr", frameErr, 0);

    // Rear capture, MSB first
    e0 = errPulses;
    sendSync();
    checkVal("first_sync_noerr", errPulses - e0, 0);
    sendWord(16'hA5C3, 16'h1234, 1'b0, 1'b0);
    checkVal("msb_word", word, 32'h1234A5C3);
    checkVal("msb_idx", wordIdx, 0);
    checkVal("msb_valid", valid, 1);
    checkVal("msb_overrun", overrun, 0);
    consume();
    checkVal("ack_drops_valid", valid, 0);

    // Overrun with ack held low
    sendWord(16'h1111, 16'h2222, 1'b0, 1'b0);
    sendWord(16'h3333, 16'h4444, 1'b0, 1'b0);
    checkVal("ovr_word_kept", word, 32'h22221111);
    checkVal("ovr_idx_kept", wordIdx, 1);
    checkVal("ovr_valid", valid, 1);
    checkVal("ovr_set", overrun, 1);
    consume();
    checkVal("ovr_sticky", overrun, 1);
    sendWord(16'h5555, 16'h6666, 1'b0, 1'b0);
    checkVal("idx_counts_dropped", wordIdx, 3);
    checkVal("after_ovr_word", word, 32'h66665555);

    // Ack in the completion cycle reloads back-to-back
    resetDut(1'b0, 1'b0);
    checkVal("rst_clears_ovr", overrun, 0);
    sendSync();
    sendWord(16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
    sendWord(16'hCCCC, 16'hDDDD, 1'b0, 1'b1);
    checkVal("b2b_word", word, 32'hDDDDCCCC);
    checkVal("b2b_idx", wordIdx, 1);
    checkVal("b2b_valid", valid, 1);
    checkVal("b2b_no_ovr", overrun, 0);

    // Front capture, LSB first
    resetDut(1'b1, 1'b1);
    sendSync();
    sendWord(16'h0001, 16'h8000, 1'b1, 1'b0);
    checkVal("lsb_word", word, 32'h80000001);
    checkVal("lsb_valid", valid, 1);

    // Frame length: 3 words is short, 4 is correct
    resetDut(1'b0, 1'b0);
    sendSync();
    for (int i = 0; i < 3; i++) begin
      sendWord(16'h0100 + 16'(i), 16'h0200 + 16'(i), 1'b0, 1'b0);
      consume();
    end
    e0 = errPulses;
    sendSync();
    checkVal("short_frame_err", errPulses - e0, 1);
    for (int i = 0; i < 4; i++) begin
      sendWord(16'h0300 + 16'(i), 16'h0400 + 16'(i), 1'b0, 1'b0);
      checkVal("frame_idx", wordIdx, i);
      if (i < 3) consume();
    end
    e0 = errPulses;
    sendSync();
    checkVal("good_frame_noerr", errPulses - e0, 0);
    checkVal("sync_keeps_valid", valid, 1);
    checkVal("sync_keeps_idx", wordIdx, 3);
    checkVal("sync_keeps_word", word, 32'h04030303);
    consume();
    sendWord(16'h0F00, 16'h00F0, 1'b0, 1'b0);
    checkVal("idx_after_sync", wordIdx, 0);
    consume();

    // Full frame then 7 bits, sync coincident with the 8th capture edge
    resetDut(1'b0, 1'b0);
    sendSync();
    for (int i = 0; i < 4; i++) begin
      sendWord(16'h7000 + 16'(i), 16'h7100 + 16'(i), 1'b0, 1'b0);
      consume();
    end
    for (int n = 0; n < 7; n++) sendBit(2'b11, 1'b0);
    e0 = errPulses;
    data = 2'b11;
    waitCyc(2);
    sync = 1'b1;
    dClk = ~dClk;
    waitCyc(5);
    sync = 1'b0;
    dClk = ~dClk;
    waitCyc(5);
    checkVal("coincident_err", errPulses - e0, 1);
    sendWord(16'hBEEF, 16'h0F0F, 1'b0, 1'b0);
    checkVal("coincident_word", word, 32'h0F0FBEEF);
    checkVal("coincident_idx", wordIdx, 0);

    // Reset mid-word
    resetDut(1'b0, 1'b0);
    sendSync();
    sendWord(16'h1234, 16'h5678, 1'b0, 1'b0);
    consume();
    sendWord(16'h9ABC, 16'hDEF0, 1'b0, 1'b0);
    pat = 16'hFFFF;
    for (int n = 0; n < 9; n++) sendBit({pat[n], pat[n]}, 1'b0);
    resetDut(1'b0, 1'b0);
    checkVal("midrst_word", word, 0);
    checkVal("midrst_idx", wordIdx, 0);
    checkVal("midrst_valid", valid, 0);
    checkVal("midrst_ovr", overrun, 0);
    sendWord(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    checkVal("idle_ignores_bits", valid, 0);
    sendSync();
    sendWord(16'h0ACE, 16'h1357, 1'b0, 1'b0);
    checkVal("resume_word", word, 32'h13570ACE);
    checkVal("resume_idx", wordIdx, 0);
    checkVal("resume_valid", valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dtfm_rx_lanes.md
DTFM_RX_LANES -- requirements
Module: dtfm_rx_lanes

Interface
REQ-001 Parameter: WORD_W, 16, bits per word per lane (4..32).
REQ-002 Parameter: LANES, 4, number of parallel data lanes sharing dClk and sync (1..8).
REQ-003 Parameter: FRAME_WORDS, 64, words per lane expected between consecutive sync fronts (2..4096).
REQ-004 Port: cClk  input  1  common clock; all logic on its rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: dClk  input  1  incoming data clock, asynchronous to cClk.
REQ-007 Port: data  input  LANES  incoming serial data, one bit per lane.
REQ-008 Port: sync  input  1  frame marker; rising front restarts framing.
REQ-009 Port: edgeSel  input  1  0 = capture on dClk rear (falling), 1 = capture on front (rising); quasi-static.
REQ-010 Port: lsbFirst  input  1  0 = first bit into word MSB, 1 = into LSB; quasi-static.
REQ-011 Port: word  output  LANES*WORD_W  held output words, lane k at bits [k*WORD_W +: WORD_W].
REQ-012 Port: wordIdx  output  clog2(FRAME_WORDS)  in-frame index of the word on word.
REQ-013 Port: valid  output  1  word/wordIdx hold an unconsumed word.
REQ-014 Port: ack  input  1  downstream consumes word when valid and ack are both high.
REQ-015 Port: overrun  output  1  sticky: a completed word was dropped.
REQ-016 Port: frameErr  output  1  one-cycle pulse: previous frame length wrong.

Function
REQ-017 dClk, sync and every data lane SHALL pass through a 3-flop synchroniser; fronts/rears are detected from stages 2 and 3.
REQ-018 On a selected capture edge, lane bits SHALL be taken from synchroniser stage 2 in the cycle the edge is detected.
REQ-019 Bit counter SHALL run 0..WORD_W-1; bit n goes to position WORD_W-1-n (lsbFirst=0) or n (lsbFirst=1).
REQ-020 FSM states: IDLE (after reset, capture edges ignored) and RECV; IDLE->RECV on sync front; RECV stays RECV.
REQ-021 On the capture edge of bit WORD_W-1, all lanes SHALL complete together; the following cycle word, wordIdx and valid=1 SHALL be presented if the holding register is free.
REQ-022 Holding register is free when valid=0, or valid=1 and ack=1 in the same cycle (back-to-back load, valid stays 1, no overrun).
REQ-023 Completion while holding register not free: new word dropped, word/wordIdx unchanged, overrun set.
REQ-024 valid SHALL drop the cycle after ack is sampled with valid=1 unless REQ-022 reloads it.
REQ-025 wordIdx counter SHALL increment per completed word (dropped or not) and wrap FRAME_WORDS-1 -> 0.
REQ-026 In RECV, sync front SHALL clear bit counter, partial shift words, word index, and received-word count (saturating at FRAME_WORDS+1).
REQ-027 In RECV, frameErr SHALL pulse the cycle after a sync front if received-word count != FRAME_WORDS or bit counter != 0; no pulse on the IDLE->RECV front.
REQ-028 Sync front and capture edge in the same cycle: sync wins, the bit is discarded.
REQ-029 Sync front SHALL NOT affect word, wordIdx, valid or overrun.

Reset
REQ-030 reset high on a cClk edge SHALL clear all synchroniser stages, counters and shift words, set FSM to IDLE, and drive word=0, wordIdx=0, valid=0, overrun=0, frameErr=0.
REQ-031 overrun SHALL clear only on reset.
REQ-032 reset mid-word SHALL discard the partial word; reception resumes only after the next sync front.

Structure
REQ-033 Package dtfm_rx_pkg SHALL hold the FSM state type and edgeSel/lsbFirst mode constants.
REQ-034 Sub-module dtfm_edge_sync (3-flop synchroniser with front/rear outputs) SHALL be used for dClk and sync.

Verification
REQ-035 WORD_W=16, LANES=2: sync front, then 16 rear-captured bits, lane0 0xA5C3 MSB-first, lane1 0x1234 -> word=0x1234A5C3, wordIdx=0, valid=1.
REQ-036 lsbFirst=1, edgeSel=1, lane0 serial bits of 0x0001 sent LSB-first -> word lane0 = 0x0001 on front capture.
REQ-037 ack held low, two words completed -> first word retained, overrun=1 until reset; ack same cycle as second completion -> no overrun.
REQ-038 FRAME_WORDS=4: sync, 3 words, sync -> frameErr one-cycle pulse; sync, 4 words, sync -> no pulse.
REQ-039 Sync front coincident with capture edge at bit 7 -> bit dropped, bit counter 0, frameErr pulse, next 16 bits form word with wordIdx=0.
REQ-040 reset asserted at bit 9 -> all outputs 0; capture edges before next sync ignored.
